// File: rtl/ilnes_uart_pkg.sv
// ---------------------------------------------------------------------------
// ilnes_uart_pkg
// Shared definitions for the UART transmit feeder:
//   - default data width, queue depth and transmitter-hang timeout
//   - FSM state encoding used by uart_tx_feeder
// ---------------------------------------------------------------------------
package ilnes_uart_pkg;

  // Default word width; matches the downstream transmit shifter.
  localparam int DEF_LENGTH  = 8;
  // Default queue depth (power of two, 2..16).
  localparam int DEF_DEPTH   = 4;
  // Default maximum WAIT cycles before the transmitter is declared hung.
  localparam int DEF_TIMEOUT = 64;

  // Feeder FSM states.
  //   ST_IDLE  : nothing in flight, pops the queue head when available
  //   ST_START : one-cycle shift-out request to the transmitter
  //   ST_WAIT  : waiting for the transmitter word-sent pulse (or timeout)
  //   ST_GAP   : one settling cycle before the next request
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Small synchronous FIFO holding words waiting for the transmitter.
//   clk      : clock, all state on the rising edge
//   rst      : synchronous active-high reset (empties the queue)
//   push     : write wr_data this cycle (ignored while full)
//   wr_data  : word to enqueue
//   pop      : remove the head word this cycle (ignored while empty)
//   rd_data  : current head word (valid while not empty)
//   count    : number of words queued, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// Pointers wrap naturally because DEPTH is a power of two. A push and a pop
// in the same cycle both take effect and leave the count unchanged.
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Status is decoded from registers only, so in_ready upstream never
  // depends combinationally on any input.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Buffers producer words in a small FIFO and hands them one at a time to a
// UART transmit shifter using a start/done handshake, with a hang detector.
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   in_data    : word offered by the producer
//   in_valid   : producer has a word on in_data
//   in_ready   : FIFO can accept a word this cycle
//   tx_data    : registered word driven to the transmitter parallel input
//   tx_start   : one-cycle shift-out request
//   tx_done    : transmitter word-sent pulse (only honoured in WAIT)
//   tx_busy    : FSM is not in IDLE
//   fifo_count : number of words currently queued
//   tx_timeout : sticky hung-transmitter flag
//   err_clear  : clears tx_timeout (a simultaneous new timeout wins)
// ---------------------------------------------------------------------------
module uart_tx_feeder
  import ilnes_uart_pkg::*;
#(
  parameter  int length  = DEF_LENGTH,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int WW      = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [length-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [length-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              tx_busy,
  output logic [CW-1:0]     fifo_count,
  output logic              tx_timeout,
  input  logic              err_clear
);

  // Elaboration-time parameter sanity checks.
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_feeder: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT <= length + 4) begin : g_bad_timeout
    $error("uart_tx_feeder: TIMEOUT must exceed length+4");
  end

  tx_state_e         state_q, state_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [WW-1:0]     wait_cnt_inc;
  logic [length-1:0] tx_data_q, tx_data_d;
  logic              timeout_q, timeout_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [length-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wait_hit;
  logic              timeout_evt;

  // -------------------------------------------------------------------------
  // Word queue
  // -------------------------------------------------------------------------
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  uart_fifo #(
    .WIDTH (length),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // -------------------------------------------------------------------------
  // Hang detection. The counter starts at 0 in the first WAIT cycle; the
  // hang is declared on the cycle whose incremented value reaches
  // TIMEOUT-1, so the sticky flag becomes visible TIMEOUT cycles after the
  // START cycle. A tx_done in that same cycle wins over the timeout.
  // -------------------------------------------------------------------------
  assign wait_cnt_inc = wait_cnt_q + 1'b1;
  assign wait_hit     = (wait_cnt_inc == WW'(TIMEOUT - 1));
  assign timeout_evt  = (state_q == ST_WAIT) && wait_hit && !tx_done;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done || wait_hit) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // One settling cycle so the transmitter is back in its wait state
        // before the next request.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register only)
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_pop = 1'b0;
    tx_start = 1'b0;
    tx_busy  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        fifo_pop = !fifo_empty;
        tx_busy  = 1'b0;
      end
      ST_START: begin
        tx_start = 1'b1;
      end
      default: begin
        tx_start = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: transmit word, wait counter, sticky error flag
  // -------------------------------------------------------------------------
  always_comb begin
    tx_data_d  = tx_data_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    // tx_data is captured at the pop and then held until the next pop, so it
    // is already stable in the START cycle.
    if (fifo_pop) begin
      tx_data_d  = fifo_rd_data;
      wait_cnt_d = '0;
    end
    if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_inc;
    end
    if (err_clear) begin
      timeout_d = 1'b0;
    end
    if (timeout_evt) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
// Self-checking bench for uart_tx_feeder (length=8, DEPTH=4, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

  localparam int LEN   = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [LEN-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] tx_data;
  logic           tx_start;
  logic           tx_done;
  logic           tx_busy;
  logic [CW-1:0]  fifo_count;
  logic           tx_timeout;
  logic           err_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .length  (LEN),
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .tx_timeout (tx_timeout),
    .err_clear  (err_clear)
  );

  typedef struct {
    bit             vld;
    logic [LEN-1:0] d;
    bit             done;
    bit             e_start;
    bit             e_busy;
    logic [LEN-1:0] e_data;
    int             e_cnt;
    bit             e_rdy;
  } vec_t;

  vec_t tab[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    tx_done   = 1'b0;
    err_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Advance until tx_start is seen, bounded by limit cycles.
  task automatic wait_start(input int limit);
    int n = 0;
    while (!tx_start && n < limit) begin
      tick();
      n++;
    end
    chk("start_seen", int'(tx_start), 1);
  endtask

  // Producer pushes n words base, base+1, ...; transmitter answers each
  // tx_start with tx_done dly cycles later. Checks order and spacing.
  task automatic stream(input int n, input int dly, input logic [LEN-1:0] base);
    int pushed    = 0;
    int started   = 0;
    int last_done = -1;
    int done_at   = -1;
    int cyc       = 0;
    logic [LEN-1:0] ev;
    while ((started < n || done_at >= 0) && cyc < 600) begin
      tx_done = 1'b0;
      if (tx_start) begin
        ev = base + LEN'(started);
        $display("stream word %0d data %02h at cycle %0d", started, tx_data, cyc);
        chk("stream_data", int'(tx_data), int'(ev));
        if (last_done >= 0) begin
          chk("stream_gap", cyc - last_done, 3);
        end
        done_at = cyc + dly;
        started++;
      end
      if (cyc == done_at) begin
        tx_done   = 1'b1;
        last_done = cyc;
        done_at   = -1;
      end
      in_valid = (pushed < n);
      in_data  = base + LEN'(pushed);
      if (in_valid && in_ready) begin
        pushed++;
      end
      tick();
      cyc++;
    end
    tx_done  = 1'b0;
    in_valid = 1'b0;
    chk("stream_count", started, n);
  endtask

  // Random traffic against a timestamp-based reference: a word popped in
  // cycle P is requested in P+1, waits from P+2 until tx_done or cycle
  // P+TIMEOUT, then one gap cycle; the feeder is busy from P+1 through the
  // gap cycle.
  task automatic run_random(input int ncyc);
    logic [LEN-1:0] mq[$];
    bit             act   = 1'b0;
    bit             flag  = 1'b0;
    int             pop_c = 0;
    int             end_c = -1;
    logic [LEN-1:0] mdata = '0;
    bit             r, v, d, e, waiting, rdy, to_evt;
    logic [LEN-1:0] w;
    for (int c = 0; c < ncyc; c++) begin
      waiting = act && (c >= pop_c + 2) && (end_c < 0);
      rdy     = (mq.size() < DEPTH);
      chk("rnd_start",   int'(tx_start),   int'(act && (c == pop_c + 1)));
      chk("rnd_busy",    int'(tx_busy),    int'(act));
      chk("rnd_count",   int'(fifo_count), mq.size());
      chk("rnd_ready",   int'(in_ready),   int'(rdy));
      chk("rnd_timeout", int'(tx_timeout), int'(flag));
      chk("rnd_data",    int'(tx_data),    int'(mdata));
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 6);
      d = ($urandom_range(0, 99) < 15);
      e = ($urandom_range(0, 99) < 4);
      w = LEN'($urandom);
      rst = r; in_valid = v; in_data = w; tx_done = d; err_clear = e;
      to_evt = 1'b0;
      if (r) begin
        mq.delete();
        act = 1'b0; flag = 1'b0; mdata = '0; end_c = -1;
      end else begin
        if (!act) begin
          if (mq.size() > 0) begin
            mdata = mq.pop_front();
            act   = 1'b1;
            pop_c = c;
            end_c = -1;
          end
        end else if (waiting) begin
          if (d) begin
            end_c = c;
          end else if (c == pop_c + TO) begin
            end_c  = c;
            to_evt = 1'b1;
          end
        end else if (end_c >= 0 && c == end_c + 1) begin
          act = 1'b0;
        end
        if (v && rdy) mq.push_back(w);
        if (to_evt) flag = 1'b1;
        else if (e) flag = 1'b0;
      end
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; tx_done = 1'b0; err_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit acc;

    // Single-word sequence: push A5, tx_start 2 cycles later, tx_done 10
    // cycles after tx_start, idle 2 cycles after tx_done, stray tx_done
    // while idle has no effect.
    tab[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1};
    tab[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b1};
    tab[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 1'b1};
    for (int i = 3; i < 12; i++) begin
      tab[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b1};
    end
    tab[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 1'b1};
    tab[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b1};
    tab[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 1'b1};
    tab[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 1'b1};

    // Reset state while rst is held high.
    rst = 1'b1; in_valid = 1'b0; in_data = 8'hFF; tx_done = 1'b0; err_clear = 1'b0;
    tick();
    tick();
    chk("rst_count",   int'(fifo_count), 0);
    chk("rst_ready",   int'(in_ready),   1);
    chk("rst_start",   int'(tx_start),   0);
    chk("rst_busy",    int'(tx_busy),    0);
    chk("rst_timeout", int'(tx_timeout), 0);
    chk("rst_data",    int'(tx_data),    0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      chk("vec_start", int'(tx_start),   int'(tab[i].e_start));
      chk("vec_busy",  int'(tx_busy),    int'(tab[i].e_busy));
      chk("vec_data",  int'(tx_data),    int'(tab[i].e_data));
      chk("vec_count", int'(fifo_count), tab[i].e_cnt);
      chk("vec_ready", int'(in_ready),   int'(tab[i].e_rdy));
      in_valid = tab[i].vld;
      in_data  = tab[i].d;
      tx_done  = tab[i].done;
      tick();
    end
    in_valid = 1'b0;
    tx_done  = 1'b0;

    // Fill: one word in flight, then 4 accepted, 5th held until a pop.
    do_reset();
    in_valid = 1'b1; in_data = 8'h20;
    tick();
    in_valid = 1'b0;
    wait_start(6);
    chk("fill_first_data", int'(tx_data), 8'h20);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h31 + LEN'(k);
      acc      = in_ready;
      tick();
      if (acc) k++;
    end
    chk("fill_accepted", k, 4);
    chk("fill_count4", int'(fifo_count), 4);
    chk("fill_ready_low", int'(in_ready), 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("fill_gap_ready", int'(in_ready), 0);
    tick();
    chk("fill_idle_count", int'(fifo_count), 4);
    tick();
    chk("fill_pop_count3", int'(fifo_count), 3);
    chk("fill_pop_ready", int'(in_ready), 1);
    chk("fill_pop_start", int'(tx_start), 1);
    chk("fill_pop_data", int'(tx_data), 8'h31);
    tick();
    in_valid = 1'b0;
    chk("fill_fifth_count", int'(fifo_count), 4);
    chk("fill_fifth_ready", int'(in_ready), 0);

    // Streaming 01..06, then 20 words to exercise pointer wrap.
    do_reset();
    stream(6, 9, 8'h01);
    do_reset();
    stream(20, 2, 8'h80);

    // Timeout: no tx_done; flag appears 16 cycles after tx_start.
    do_reset();
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_data = 8'h78;
    tick();
    in_valid = 1'b0;
    wait_start(6);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("to_not_yet", int'(tx_timeout), 0);
      if (i == 16) chk("to_set", int'(tx_timeout), 1);
    end
    tick();
    tick();
    chk("to_next_start", int'(tx_start), 1);
    chk("to_next_data", int'(tx_data), 8'h78);
    chk("to_still_set", int'(tx_timeout), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("to_cleared", int'(tx_timeout), 0);

    // Reset mid-WAIT with 3 words queued.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h41 + LEN'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("rw_queued", int'(fifo_count), 3);
    chk("rw_busy", int'(tx_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_count0", int'(fifo_count), 0);
    chk("rw_busy0", int'(tx_busy), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rw_no_start", int'(tx_start), 0);
      chk("rw_idle", int'(tx_busy), 0);
    end

    // Simultaneous push and pop in IDLE with two words queued.
    do_reset();
    in_valid = 1'b1; in_data = 8'h51;
    tick();
    in_valid = 1'b0;
    wait_start(6);
    in_valid = 1'b1; in_data = 8'h52;
    tick();
    in_data = 8'h53;
    tick();
    in_valid = 1'b0;
    chk("pp_count2", int'(fifo_count), 2);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    chk("pp_idle_count", int'(fifo_count), 2);
    chk("pp_idle_busy", int'(tx_busy), 0);
    in_valid = 1'b1; in_data = 8'h54;
    tick();
    in_valid = 1'b0;
    chk("pp_count_kept", int'(fifo_count), 2);
    chk("pp_start", int'(tx_start), 1);
    chk("pp_data", int'(tx_data), 8'h52);

    // Randomized traffic against the reference model.
    do_reset();
    run_random(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter: length, default 8, data word width in bits; matches the downstream transmit shifter.
REQ-002 Parameter: DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-003 Parameter: TIMEOUT, default 64, maximum WAIT cycles before the transmitter is declared hung; must be greater than length+4.
REQ-004 Port: clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port: rst, input, 1, reset; synchronous and active-high.
REQ-006 Port: in_data, input, length, word offered by the producer.
REQ-007 Port: in_valid, input, 1, producer has a word on in_data.
REQ-008 Port: in_ready, output, 1, FIFO can accept a word this cycle.
REQ-009 Port: tx_data, output, length, registered word driven to the transmitter parallel input.
REQ-010 Port: tx_start, output, 1, one-cycle shift-out request to the transmitter.
REQ-011 Port: tx_done, input, 1, transmitter word-sent pulse.
REQ-012 Port: tx_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-013 Port: fifo_count, output, clog2(DEPTH)+1, number of words currently queued.
REQ-014 Port: tx_timeout, output, 1, sticky hung-transmitter flag.
REQ-015 Port: err_clear, input, 1, clears tx_timeout.

Function
REQ-016 A push SHALL occur when in_valid && in_ready; in_ready SHALL be (fifo_count != DEPTH), decoded from registers only.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH; a simultaneous push and pop SHALL leave fifo_count unchanged and both SHALL take effect.
REQ-018 The FSM SHALL have four states: IDLE, START, WAIT, GAP.
REQ-019 IDLE behaviour:
- If fifo_count != 0: pop the head into tx_data, clear the wait counter, go to START.
- Otherwise stay in IDLE.
REQ-020 START SHALL assert tx_start for exactly that one cycle and go to WAIT.
REQ-021 WAIT behaviour:
- Increment the wait counter each cycle.
- On tx_done: go to GAP.
- If the counter reaches TIMEOUT-1 without tx_done: set tx_timeout and go to GAP.
- If both occur in the same cycle, tx_done wins and tx_timeout is not set.
REQ-022 GAP SHALL last one cycle and then return to IDLE; it guarantees the transmitter has re-entered its wait state before the next tx_start.
REQ-023 tx_data SHALL hold stable from the START cycle until the next pop.
REQ-024 tx_done outside WAIT SHALL be ignored.
REQ-025 Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE SHALL produce tx_start high during cycle N+2.
REQ-026 Back-to-back spacing SHALL be tx_done cycle, then GAP, then IDLE, then START; the minimum is 3 cycles from tx_done to the next tx_start.
REQ-027 tx_timeout SHALL stay set until err_clear or rst; if err_clear and a new timeout occur in the same cycle, set wins.
REQ-028 A push while full SHALL be impossible by handshake; in_data SHALL be ignored whenever in_ready is low.

Reset
REQ-029 While rst is high at a clock edge, all of the following SHALL hold:
- FSM is in IDLE and pointers are 0.
- fifo_count=0, in_ready=1.
- tx_start=0, tx_data=0, tx_busy=0, tx_timeout=0, wait counter=0.
REQ-030 Reset mid-operation SHALL discard all queued words and the in-flight word; no tx_start SHALL be issued in the cycle after rst deasserts.

Structure
REQ-031 FSM state encoding and the default length, DEPTH and TIMEOUT constants SHALL live in shared package ilnes_uart_pkg.
REQ-032 Queue storage and pointers SHALL be a sub-module uart_fifo (sync FIFO: push, pop, count, full, empty); the FSM, wait counter and error flag SHALL stay in uart_tx_feeder.

Verification
REQ-033 Single word: after reset push 8'hA5 -> tx_start exactly one cycle, 2 cycles after the push; tx_data=8'hA5; tx_done after 10 cycles -> tx_busy low 2 cycles later.
REQ-034 Fill: push 5 words with tx_done withheld -> in_ready low after 4 accepted; fifo_count=4 then 3 after first pop; 5th word accepted only after a pop.
REQ-035 Streaming: 6 words 01..06 with tx_done 9 cycles after each tx_start -> tx_data sequence 01..06 in order, each tx_start 3 cycles after the previous tx_done.
REQ-036 Timeout: TIMEOUT=16, tx_done never asserted -> tx_timeout set 16 cycles after tx_start, next word started, err_clear drops flag.
REQ-037 Reset mid-WAIT with 3 words queued -> fifo_count=0, tx_busy=0, no tx_start for 5 cycles after rst with in_valid low.
REQ-038 Simultaneous push and pop in IDLE with fifo_count=2 -> fifo_count stays 2; pointer wrap verified over 20 words.
